// File: rtl/lcdi_seq_ctrl_if.sv
// Pixel handshake bundle between the LCDI sequencer, the pixel-window source
// and the result sink.
interface lcdi_seq_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    // Environment side: offers pixels and accepts results.
    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

    // Sequencer side.
    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid
    );
endinterface

// File: rtl/lcdi_seq_ctrl.sv
// LCDI per-pixel sequencer: steps the 3-bit stage code for each accepted pixel,
// tracks column/row within the frame and routes border pixels straight from
// STATE1 to STATE7, skipping the interpolation stages.
module lcdi_seq_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int COL_W = 10,
    parameter int ROW_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    lcdi_seq_ctrl_if.slave   hs,
    output logic [2:0]       LCDI_state,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             border,
    output logic             line_end,
    output logic             frame_done,
    output logic             busy
);

    typedef enum logic [2:0] {
        LCDI_STATE0 = 3'd0,
        LCDI_STATE1 = 3'd1,
        LCDI_STATE2 = 3'd2,
        LCDI_STATE3 = 3'd3,
        LCDI_STATE4 = 3'd4,
        LCDI_STATE5 = 3'd5,
        LCDI_STATE6 = 3'd6,
        LCDI_STATE7 = 3'd7
    } state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             border_q, border_d;
    logic             line_end_q, line_end_d;
    logic             frame_done_q, frame_done_d;

    // State and position registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= LCDI_STATE0;
            busy_q       <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            border_q     <= 1'b0;
            line_end_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            col_q        <= col_d;
            row_q        <= row_d;
            border_q     <= border_d;
            line_end_q   <= line_end_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic: arming, accept, stage stepping and pixel retire.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        col_d        = col_q;
        row_d        = row_q;
        border_d     = border_q;
        line_end_d   = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            LCDI_STATE0: begin
                if (!busy_q) begin
                    // Idle: only frame_start matters; in_valid is ignored.
                    if (frame_start) begin
                        busy_d = 1'b1;
                        col_d  = '0;
                        row_d  = '0;
                    end else begin
                        state_d = LCDI_STATE0;
                    end
                end else if (hs.in_valid) begin
                    state_d  = LCDI_STATE1;
                    border_d = (col_q == '0) || (col_q == LAST_COL) ||
                               (row_q == '0) || (row_q == LAST_ROW);
                end else begin
                    state_d = LCDI_STATE0;
                end
            end
            LCDI_STATE1: state_d = border_q ? LCDI_STATE7 : LCDI_STATE2;
            LCDI_STATE2: state_d = LCDI_STATE3;
            LCDI_STATE3: state_d = LCDI_STATE4;
            LCDI_STATE4: state_d = LCDI_STATE5;
            LCDI_STATE5: state_d = LCDI_STATE6;
            LCDI_STATE6: state_d = LCDI_STATE7;
            LCDI_STATE7: begin
                if (hs.out_ready) begin
                    state_d = LCDI_STATE0;
                    if (col_q == LAST_COL) begin
                        col_d      = '0;
                        line_end_d = 1'b1;
                        if (row_q == LAST_ROW) begin
                            // Last pixel of the frame: busy drops at this edge,
                            // so a coincident frame_start cannot re-arm.
                            row_d        = '0;
                            frame_done_d = 1'b1;
                            busy_d       = 1'b0;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end else begin
                    state_d = LCDI_STATE7;
                end
            end
            default: state_d = LCDI_STATE0;
        endcase
    end

    assign hs.in_ready  = busy_q && (state_q == LCDI_STATE0);
    assign hs.out_valid = (state_q == LCDI_STATE7);
    assign LCDI_state   = state_q;
    assign col          = col_q;
    assign row          = row_q;
    assign border       = border_q;
    assign line_end     = line_end_q;
    assign frame_done   = frame_done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_lcdi_seq_ctrl.sv
// Directed bench for lcdi_seq_ctrl on a 4x3 frame.
module tb_lcdi_seq_ctrl;

    localparam int W = 4;
    localparam int H = 3;

    logic       clk;
    logic       rst_n;
    logic       frame_start;
    logic [2:0] LCDI_state;
    logic [1:0] col;
    logic [1:0] row;
    logic       border;
    logic       line_end;
    logic       frame_done;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;
    int le_cnt = 0;
    int fd_cnt = 0;
    int s6_cnt = 0;
    int hs_snap;

    lcdi_seq_ctrl_if bus ();

    lcdi_seq_ctrl #(.IMG_W(W), .IMG_H(H), .COL_W(2), .ROW_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .hs         (bus),
        .LCDI_state (LCDI_state),
        .col        (col),
        .row        (row),
        .border     (border),
        .line_end   (line_end),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled at the active edge.
    always @(posedge clk) begin
        if (bus.out_valid && bus.out_ready) hs_cnt <= hs_cnt + 1;
        if (line_end)   le_cnt <= le_cnt + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (LCDI_state == 3'd6) s6_cnt <= s6_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pixel from accept to retire; assumes state 0, busy, in_valid=1.
    task automatic run_pixel(input int c, input int r, input logic b, input int hold);
        int nc, nr;
        logic last;
        bus.out_ready = (hold == 0);
        step;
        chk("acc_state",  32'(LCDI_state), 1);
        chk("acc_border", 32'(border), 32'(b));
        chk("acc_col",    32'(col), c);
        chk("acc_row",    32'(row), r);
        chk("acc_rdy",    32'(bus.in_ready), 0);
        chk("acc_ov",     32'(bus.out_valid), 0);
        chk("acc_le",     32'(line_end), 0);
        if (b) begin
            step;
            chk("bp_state", 32'(LCDI_state), 7);
            chk("bp_ov",    32'(bus.out_valid), 1);
        end else begin
            for (int s = 2; s <= 7; s++) begin
                step;
                chk("int_state", 32'(LCDI_state), s);
                chk("int_ov",    32'(bus.out_valid), 32'(s == 7));
            end
        end
        for (int h = 0; h < hold; h++) begin
            step;
            chk("hold_state", 32'(LCDI_state), 7);
            chk("hold_ov",    32'(bus.out_valid), 1);
            chk("hold_col",   32'(col), c);
            chk("hold_row",   32'(row), r);
            chk("hold_rdy",   32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        step;
        last = (c == W - 1) && (r == H - 1);
        nc = (c == W - 1) ? 0 : c + 1;
        nr = (c == W - 1) ? ((r == H - 1) ? 0 : r + 1) : r;
        chk("ret_state", 32'(LCDI_state), 0);
        chk("ret_ov",    32'(bus.out_valid), 0);
        chk("ret_col",   32'(col), nc);
        chk("ret_row",   32'(row), nr);
        chk("ret_le",    32'(line_end), 32'(c == W - 1));
        chk("ret_fd",    32'(frame_done), 32'(last));
        chk("ret_busy",  32'(busy), 32'(!last));
        chk("ret_rdy",   32'(bus.in_ready), 32'(!last));
    endtask

    initial begin
        // Reset with active-looking inputs.
        rst_n = 1'b0;
        frame_start = 1'b1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        step;
        step;
        chk("rst_state",  32'(LCDI_state), 0);
        chk("rst_busy",   32'(busy), 0);
        chk("rst_col",    32'(col), 0);
        chk("rst_row",    32'(row), 0);
        chk("rst_border", 32'(border), 0);
        chk("rst_le",     32'(line_end), 0);
        chk("rst_fd",     32'(frame_done), 0);
        chk("rst_rdy",    32'(bus.in_ready), 0);
        chk("rst_ov",     32'(bus.out_valid), 0);
        rst_n = 1'b1;
        frame_start = 1'b0;
        step;
        step;
        chk("idle_busy",  32'(busy), 0);
        chk("idle_state", 32'(LCDI_state), 0);
        chk("idle_rdy",   32'(bus.in_ready), 0);

        // Arm and run the whole 4x3 frame with in_valid held high.
        frame_start = 1'b1;
        bus.in_valid = 1'b0;
        step;
        frame_start = 1'b0;
        bus.in_valid = 1'b1;
        chk("arm_busy", 32'(busy), 1);
        chk("arm_rdy",  32'(bus.in_ready), 1);
        chk("arm_col",  32'(col), 0);
        run_pixel(0, 0, 1'b1, 0);
        run_pixel(1, 0, 1'b1, 0);
        run_pixel(2, 0, 1'b1, 0);
        run_pixel(3, 0, 1'b1, 0);
        run_pixel(0, 1, 1'b1, 0);
        run_pixel(1, 1, 1'b0, 0);
        run_pixel(2, 1, 1'b0, 5);
        run_pixel(3, 1, 1'b1, 0);
        run_pixel(0, 2, 1'b1, 0);
        frame_start = 1'b1;
        run_pixel(1, 2, 1'b1, 0);
        frame_start = 1'b0;
        run_pixel(2, 2, 1'b1, 0);
        frame_start = 1'b1;
        run_pixel(3, 2, 1'b1, 0);
        frame_start = 1'b0;
        step;
        chk("post_busy", 32'(busy), 0);
        chk("post_fd",   32'(frame_done), 0);
        chk("post_le",   32'(line_end), 0);
        chk("post_rdy",  32'(bus.in_ready), 0);
        chk("frame_handshakes", hs_cnt, 12);
        chk("frame_line_ends",  le_cnt, 3);
        chk("frame_dones",      fd_cnt, 1);
        chk("frame_state6",     s6_cnt, 2);

        // Second frame, reset while pixel (2,1) is in STATE4.
        frame_start = 1'b1;
        step;
        frame_start = 1'b0;
        chk("arm2_busy", 32'(busy), 1);
        run_pixel(0, 0, 1'b1, 0);
        run_pixel(1, 0, 1'b1, 0);
        run_pixel(2, 0, 1'b1, 0);
        run_pixel(3, 0, 1'b1, 0);
        run_pixel(0, 1, 1'b1, 0);
        run_pixel(1, 1, 1'b0, 0);
        step;
        chk("mid_acc_state",  32'(LCDI_state), 1);
        chk("mid_acc_border", 32'(border), 0);
        chk("mid_acc_col",    32'(col), 2);
        step;
        step;
        step;
        chk("mid_state4", 32'(LCDI_state), 4);
        hs_snap = hs_cnt;
        rst_n = 1'b0;
        step;
        chk("mrst_state", 32'(LCDI_state), 0);
        chk("mrst_col",   32'(col), 0);
        chk("mrst_row",   32'(row), 0);
        chk("mrst_busy",  32'(busy), 0);
        chk("mrst_ov",    32'(bus.out_valid), 0);
        rst_n = 1'b1;
        step;
        chk("mrst_idle_rdy",   32'(bus.in_ready), 0);
        chk("mrst_idle_state", 32'(LCDI_state), 0);
        chk("mrst_no_output",  hs_cnt, hs_snap);
        frame_start = 1'b1;
        step;
        frame_start = 1'b0;
        chk("rearm_busy", 32'(busy), 1);
        step;
        chk("rearm_state",  32'(LCDI_state), 1);
        chk("rearm_border", 32'(border), 1);
        chk("rearm_col",    32'(col), 0);
        chk("rearm_row",    32'(row), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
